// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind the UART receiver.
// Parses SYNC/ADDR/LEN/payload/checksum frames from the receiver's level-valid byte stream.
// The payload is buffered and written to the register file only after the checksum matches.
module uart_rx_pkt_ctrl #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned MAX_LEN   = 16,
   parameter int unsigned TIMEOUT   = 2048
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       pkt_done,
   output logic       pkt_err,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int unsigned IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [8:0]    MAX_LEN9 = 9'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_PAYLOAD,
      S_CHK,
      S_COMMIT
   } state_t;

   state_t        state, state_n;
   logic          rx_valid_q;
   logic          byte_ev;
   logic          in_pkt;
   logic [7:0]    base_q, base_n;
   logic [8:0]    len_q, len_n;
   logic [8:0]    idx_q, idx_n;
   logic [7:0]    chk_q, chk_n;
   logic [TW-1:0] tmo_q, tmo_n;
   logic          wr_en_n, pkt_done_n, pkt_err_n;
   logic [7:0]    wr_addr_n, wr_data_n;
   logic [1:0]    err_code_n;
   logic          buf_we;
   logic [7:0]    pbuf [MAX_LEN];

   assign byte_ev = rx_valid & ~rx_valid_q;
   assign in_pkt  = (state == S_ADDR) || (state == S_LEN) ||
                    (state == S_PAYLOAD) || (state == S_CHK);

   // State, parser context and all outputs are registered here.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= S_IDLE;
         rx_valid_q <= 1'b0;
         base_q     <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         chk_q      <= '0;
         tmo_q      <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         pkt_done   <= 1'b0;
         pkt_err    <= 1'b0;
         err_code   <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         rx_valid_q <= rx_valid;
         base_q     <= base_n;
         len_q      <= len_n;
         idx_q      <= idx_n;
         chk_q      <= chk_n;
         tmo_q      <= tmo_n;
         wr_en      <= wr_en_n;
         wr_addr    <= wr_addr_n;
         wr_data    <= wr_data_n;
         pkt_done   <= pkt_done_n;
         pkt_err    <= pkt_err_n;
         err_code   <= err_code_n;
         busy       <= (state_n != S_IDLE);
      end
   end

   // Payload buffer; contents are meaningless until a full payload has been captured.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         pbuf[idx_q[IW-1:0]] <= rx_data;
      end
   end

   // Next-state and next-output decode; a timeout only fires when no byte arrives that cycle.
   always_comb begin
      state_n    = state;
      base_n     = base_q;
      len_n      = len_q;
      idx_n      = idx_q;
      chk_n      = chk_q;
      tmo_n      = tmo_q;
      wr_en_n    = 1'b0;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      pkt_done_n = 1'b0;
      pkt_err_n  = 1'b0;
      err_code_n = err_code;
      buf_we     = 1'b0;

      if (byte_ev) begin
         tmo_n = '0;
      end else if (in_pkt) begin
         tmo_n = tmo_q + 1'b1;
      end

      if (in_pkt && !byte_ev && (tmo_q == TMO_LAST)) begin
         pkt_err_n  = 1'b1;
         err_code_n = 2'b11;
         tmo_n      = '0;
         state_n    = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (byte_ev && (rx_data == SYNC_BYTE)) begin
                  state_n = S_ADDR;
               end
            end
            S_ADDR: begin
               if (byte_ev) begin
                  base_n  = rx_data;
                  state_n = S_LEN;
               end
            end
            S_LEN: begin
               if (byte_ev) begin
                  if ((rx_data == 8'd0) || ({1'b0, rx_data} > MAX_LEN9)) begin
                     pkt_err_n  = 1'b1;
                     err_code_n = 2'b01;
                     state_n    = S_IDLE;
                  end else begin
                     len_n   = {1'b0, rx_data};
                     chk_n   = base_q ^ rx_data;
                     idx_n   = '0;
                     state_n = S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (byte_ev) begin
                  buf_we = 1'b1;
                  chk_n  = chk_q ^ rx_data;
                  idx_n  = idx_q + 9'd1;
                  if ((idx_q + 9'd1) == len_q) begin
                     state_n = S_CHK;
                  end
               end
            end
            S_CHK: begin
               if (byte_ev) begin
                  if (rx_data == chk_q) begin
                     idx_n   = '0;
                     state_n = S_COMMIT;
                  end else begin
                     pkt_err_n  = 1'b1;
                     err_code_n = 2'b10;
                     state_n    = S_IDLE;
                  end
               end
            end
            S_COMMIT: begin
               // Incoming bytes are ignored here; only the write sequence advances.
               if (idx_q != len_q) begin
                  wr_en_n   = 1'b1;
                  wr_addr_n = base_q + idx_q[7:0];
                  wr_data_n = pbuf[idx_q[IW-1:0]];
                  idx_n     = idx_q + 9'd1;
               end else begin
                  pkt_done_n = 1'b1;
                  state_n    = S_IDLE;
               end
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: expected writes and packet outcomes are queued
// as each packet is driven and popped by a monitor when the DUT produces them.
module tb_uart_rx_pkt_ctrl;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = '0;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       pkt_done;
   logic       pkt_err;
   logic [1:0] err_code;
   logic       busy;

   typedef struct packed {
      logic       is_done;
      logic [1:0] code;
      logic [7:0] nwr;
   } evt_t;

   logic [15:0] exp_wr[$];
   evt_t        evq[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          run_len = 0;
   int          last_run = 0;
   logic [7:0]  pl [16];

   uart_rx_pkt_ctrl #(
      .SYNC_BYTE(8'hA5),
      .MAX_LEN(16),
      .TIMEOUT(2048)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .pkt_done(pkt_done),
      .pkt_err(pkt_err),
      .err_code(err_code),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One receiver byte: valid held for 3 cycles (must yield a single event), then low.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_writes(input logic [7:0] base, input int n);
      logic [7:0] a;
      a = base;
      for (int i = 0; i < n; i++) begin
         exp_wr.push_back({a, pl[i]});
         a = a + 8'd1;
      end
   endtask

   task automatic expect_done(input logic [7:0] n);
      evq.push_back('{is_done: 1'b1, code: 2'b00, nwr: n});
   endtask

   task automatic expect_err(input logic [1:0] c);
      evq.push_back('{is_done: 1'b0, code: c, nwr: 8'd0});
   endtask

   task automatic good_packet();
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      expect_writes(8'h10, 3);
      expect_done(8'd3);
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h13);
      idle(6);
      chk("good_drain_wr", exp_wr.size(), 0);
      chk("good_drain_evt", evq.size(), 0);
   endtask

   initial begin
      evt_t ev;
      logic seen;

      // Monitor: pops scoreboard entries as writes and packet outcomes appear.
      fork
         forever begin
            @(negedge clk);
            if (n_rst) begin
               if (wr_en) begin
                  run_len++;
                  if (exp_wr.size() == 0) chk("unexpected_wr", wr_en, 1'b0);
                  else chk("wr_addr_data", {wr_addr, wr_data}, exp_wr.pop_front());
               end else begin
                  if (run_len != 0) last_run = run_len;
                  run_len = 0;
               end
               if (pkt_done || pkt_err) begin
                  chk("done_err_exclusive", pkt_done & pkt_err, 1'b0);
                  if (evq.size() == 0) chk("unexpected_evt", {pkt_done, pkt_err}, 2'b00);
                  else begin
                     ev = evq.pop_front();
                     chk("busy_at_end", busy, 1'b0);
                     if (ev.is_done) begin
                        chk("pkt_done", pkt_done, 1'b1);
                        chk("write_burst_len", last_run, ev.nwr);
                        last_run = 0;
                     end else begin
                        chk("pkt_err", pkt_err, 1'b1);
                        chk("err_code", err_code, ev.code);
                     end
                  end
               end
            end
         end
      join_none

      // Reset state
      #1;
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_wr_addr", wr_addr, 8'h00);
      chk("rst_wr_data", wr_data, 8'h00);
      chk("rst_pkt_done", pkt_done, 1'b0);
      chk("rst_pkt_err", pkt_err, 1'b0);
      chk("rst_err_code", err_code, 2'b00);
      chk("rst_busy", busy, 1'b0);
      idle(3);
      n_rst = 1'b1;
      idle(2);

      // Good packet
      good_packet();

      // Bad checksum, then a good packet still commits
      expect_err(2'b10);
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h14);
      idle(4);
      chk("badchk_drain", evq.size(), 0);
      good_packet();

      // Bad length: zero and MAX_LEN+1
      expect_err(2'b01);
      send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00);
      idle(4);
      expect_err(2'b01);
      send_byte(8'hA5); send_byte(8'h20); send_byte(8'h11);
      idle(4);
      chk("badlen_drain", evq.size(), 0);

      // Noise before SYNC and address wrap
      pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
      expect_writes(8'hFE, 3);
      expect_done(8'd3);
      send_byte(8'h55); send_byte(8'hA5); send_byte(8'hFE); send_byte(8'h03);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'hFD);
      idle(6);
      chk("wrap_drain_wr", exp_wr.size(), 0);
      chk("wrap_drain_evt", evq.size(), 0);

      // Timeout: ADDR byte event at edge E0, nothing more; error lands on edge E2048
      expect_err(2'b11);
      send_byte(8'hA5);
      @(negedge clk); rx_data = 8'h10; rx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk); rx_valid = 1'b0;
      repeat (2047) @(posedge clk);
      #1;
      chk("tmo_not_early", pkt_err, 1'b0);
      chk("tmo_busy_before", busy, 1'b1);
      @(posedge clk);
      #1;
      chk("tmo_pkt_err", pkt_err, 1'b1);
      chk("tmo_code", err_code, 2'b11);
      chk("tmo_busy_after", busy, 1'b0);
      idle(3);

      // Timeout boundary: byte arriving on the final cycle is accepted as LEN=1
      pl[0] = 8'h5A;
      expect_writes(8'h10, 1);
      expect_done(8'd1);
      send_byte(8'hA5);
      @(negedge clk); rx_data = 8'h10; rx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk); rx_valid = 1'b0;
      repeat (2047) @(posedge clk);
      @(negedge clk); rx_data = 8'h01; rx_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("tmo_edge_no_err", pkt_err, 1'b0);
      chk("tmo_edge_busy", busy, 1'b1);
      @(negedge clk); rx_valid = 1'b0;
      send_byte(8'h5A); send_byte(8'h4B);
      idle(6);
      chk("tmo_edge_drain_wr", exp_wr.size(), 0);
      chk("tmo_edge_drain_evt", evq.size(), 0);

      // Reset during the second write of a good packet
      pl[0] = 8'h11;
      expect_writes(8'h10, 1);
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      @(negedge clk); rx_data = 8'h13; rx_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         seen = wr_en;
      end
      chk("rst_wait_first_wr", seen, 1'b1);
      @(posedge clk);
      #1;
      chk("rst_second_wr_en", wr_en, 1'b1);
      chk("rst_second_wr_addr", wr_addr, 8'h11);
      n_rst = 1'b0;
      rx_valid = 1'b0;
      #1;
      chk("mid_rst_wr_en", wr_en, 1'b0);
      chk("mid_rst_wr_addr", wr_addr, 8'h00);
      chk("mid_rst_wr_data", wr_data, 8'h00);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", pkt_done, 1'b0);
      chk("mid_rst_err", pkt_err, 1'b0);
      chk("mid_rst_code", err_code, 2'b00);
      idle(3);
      n_rst = 1'b1;
      idle(8);
      chk("mid_rst_drain_wr", exp_wr.size(), 0);
      good_packet();

      idle(4);
      chk("final_drain_wr", exp_wr.size(), 0);
      chk("final_drain_evt", evq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
Packet controller behind the UART receiver. It detects each completed byte from the receiver's level-valid output and parses framed write packets: SYNC, ADDR, LEN, payload, checksum. The payload is buffered internally and is committed to a register-file write port only after the checksum passes. Errors and inter-byte timeouts are reported as one-cycle pulses with a code.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
MAX_LEN, 16, maximum payload bytes per packet (1..256)
TIMEOUT, 2048, max clk cycles allowed between bytes inside a packet

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous, active-low reset
rx_valid  in  1  receiver valid (level; rises when byte complete, falls after stop bit)
rx_data  in  8  receiver byte, stable while rx_valid high
wr_en  out  1  register write strobe
wr_addr  out  8  register write address
wr_data  out  8  register write data
pkt_done  out  1  one-cycle pulse: packet committed
pkt_err  out  1  one-cycle pulse: packet dropped
err_code  out  2  01 bad LEN, 10 bad checksum, 11 timeout; held until next pkt_err
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE. wr_en, wr_addr, wr_data, pkt_done, pkt_err, err_code, busy = 0. Edge register, counters and buffer index = 0. Buffer contents are don't-care.
- Byte event: rx_valid=1 and rx_valid_q=0, where rx_valid_q is rx_valid registered. The FSM consumes rx_data on that same clock edge. rx_valid held high produces exactly one event.
- All outputs are registered.
- IDLE: on a byte event equal to SYNC_BYTE -> ADDR. Any other byte is ignored silently.
- ADDR: byte event -> latch base address -> LEN.
- LEN: byte event. If the value is 0 or greater than MAX_LEN: pkt_err=1, err_code=01, -> IDLE. Otherwise latch LEN, set chk = ADDR ^ LEN, index=0 -> PAYLOAD.
- PAYLOAD: each byte event writes buf[index], sets chk ^= byte, index++. The event that makes index==LEN moves to CHK.
- CHK: byte event. If byte == chk -> COMMIT with index=0. Otherwise pkt_err=1, err_code=10, -> IDLE.
- COMMIT: one write per cycle, starting the cycle after the checksum byte edge. wr_en=1, wr_addr=(ADDR+i) mod 256 (8-bit wrap), wr_data=buf[i], for i=0..LEN-1 on consecutive cycles. The cycle after the last write: wr_en=0, pkt_done=1, -> IDLE. Byte events during COMMIT are discarded and do not flag an error.
- wr_addr/wr_data are held at their last values when wr_en=0.
- Timeout: the counter clears on every byte event and increments each cycle in ADDR/LEN/PAYLOAD/CHK. When it reaches TIMEOUT-1 with no byte event in that cycle: pkt_err=1, err_code=11, -> IDLE. A byte event in the same cycle wins. The counter is idle outside these states.
- A SYNC_BYTE value inside ADDR/LEN/PAYLOAD/CHK is treated as ordinary data (no resync).
- pkt_err and pkt_done are never asserted together. Any error leaves wr_en untouched, so no partial writes occur.
- n_rst asserted mid-packet or mid-COMMIT: wr_en drops asynchronously, remaining writes are abandoned, FSM returns to IDLE.
- busy=1 from the cycle after the SYNC accept until the cycle the FSM returns to IDLE.

Test Plan:
- Good packet: bytes A5 10 03 11 22 33 13 -> wr_en for 3 consecutive cycles with (addr,data) = (10,11),(11,22),(12,33). Then pkt_done pulse; pkt_err stays 0.
- Bad checksum: A5 10 03 11 22 33 14 -> no wr_en, pkt_err pulse, err_code=10. A following good packet still commits.
- Bad length: A5 20 00 and A5 20 11 (LEN 17 > MAX_LEN 16) -> pkt_err with err_code=01 each time, no writes.
- Address wrap and noise: 55 A5 FE 03 01 02 03 FD -> leading 55 ignored. Writes (FE,01),(FF,02),(00,03), then pkt_done.
- Timeout: A5 10, then rx_valid held low for 2048 cycles -> pkt_err with err_code=11, busy=0. A byte arriving exactly on the final cycle is accepted instead.
- Reset mid-COMMIT: assert n_rst during the 2nd write of the good packet -> all outputs 0 immediately, no further writes. The next good packet commits normally.
